// File: rtl/memory_request_master.sv
// PDP-8 memory request master: sequences fetch/read/write/ISZ requests
// into the controller enable-pulse / operation_done handshake.
module memory_request_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_address,
    input  logic [11:0] req_write_data,
    output logic        rsp_valid,
    output logic [11:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_error,
    output logic [11:0] mem_address,
    output logic [11:0] mem_write_data,
    output logic        mem_read_enable,
    output logic        mem_read_type,
    output logic        mem_write_enable,
    input  logic [11:0] mem_read_data,
    input  logic        mem_operation_done
);

    localparam logic       DATA_READ         = 1'b0;
    localparam logic       INSTRUCTION_FETCH = 1'b1;
    localparam logic [1:0] OP_FETCH          = 2'b00;
    localparam logic [1:0] OP_WRITE          = 2'b10;
    localparam logic [1:0] OP_RMW            = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        RESPOND
    } state_t;

    state_t      state;
    state_t      next;
    logic [1:0]  op_q;
    logic [7:0]  cnt;
    logic        done_q;
    logic        done_edge;
    logic        timed_out;
    logic        accept;
    logic [11:0] inc;

    assign done_edge = mem_operation_done & ~done_q;
    assign timed_out = (cnt == 8'(TIMEOUT_CYCLES));
    assign accept    = req_valid & req_ready;
    assign inc       = mem_read_data + 12'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next             = state;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next = (req_op == OP_WRITE) ? WR_ISSUE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                mem_read_enable = 1'b1;
                next            = RD_WAIT;
            end
            RD_WAIT: begin
                if (done_edge) begin
                    next = (op_q == OP_RMW) ? WR_ISSUE : RESPOND;
                end else if (timed_out) begin
                    next = RESPOND;
                end
            end
            WR_ISSUE: begin
                mem_write_enable = 1'b1;
                next             = WR_WAIT;
            end
            WR_WAIT: begin
                if (done_edge || timed_out) begin
                    next = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                next      = IDLE;
            end
            default: next = IDLE;
        endcase
        // Nothing leaves the block while reset is being sampled.
        if (reset) begin
            req_ready        = 1'b0;
            rsp_valid        = 1'b0;
            mem_read_enable  = 1'b0;
            mem_write_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q           <= 2'b00;
            cnt            <= 8'd0;
            done_q         <= 1'b0;
            mem_address    <= 12'd0;
            mem_write_data <= 12'd0;
            mem_read_type  <= DATA_READ;
            rsp_data       <= 12'd0;
            rsp_zero       <= 1'b0;
            rsp_error      <= 1'b0;
        end else begin
            done_q <= mem_operation_done;
            if (accept) begin
                op_q           <= req_op;
                mem_address    <= req_address;
                mem_write_data <= req_write_data;
                mem_read_type  <= (req_op == OP_FETCH) ? INSTRUCTION_FETCH
                                                       : DATA_READ;
            end
            if (state == RD_ISSUE || state == WR_ISSUE) begin
                cnt <= 8'd0;
            end else if (state == RD_WAIT || state == WR_WAIT) begin
                cnt <= cnt + 8'd1;
            end
            if (state == RD_WAIT) begin
                if (done_edge) begin
                    if (op_q == OP_RMW) begin
                        mem_write_data <= inc;
                    end else begin
                        rsp_data  <= mem_read_data;
                        rsp_zero  <= 1'b0;
                        rsp_error <= 1'b0;
                    end
                end else if (timed_out) begin
                    rsp_data  <= 12'd0;
                    rsp_zero  <= 1'b0;
                    rsp_error <= 1'b1;
                end
            end
            if (state == WR_WAIT) begin
                if (done_edge) begin
                    rsp_data  <= mem_write_data;
                    rsp_zero  <= (op_q == OP_RMW) && (mem_write_data == 12'd0);
                    rsp_error <= 1'b0;
                end else if (timed_out) begin
                    rsp_data  <= 12'd0;
                    rsp_zero  <= 1'b0;
                    rsp_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_request_master.sv
// Bench for memory_request_master: controller model answering 3 cycles
// after each enable, plus a response scoreboard.
module tb_memory_request_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [11:0] req_address = 12'd0;
    logic [11:0] req_write_data = 12'd0;
    logic        rsp_valid;
    logic [11:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_error;
    logic [11:0] mem_address;
    logic [11:0] mem_write_data;
    logic        mem_read_enable;
    logic        mem_read_type;
    logic        mem_write_enable;
    logic [11:0] mem_read_data;
    logic        mem_operation_done;

    always #5 clk = ~clk;

    memory_request_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_address        (req_address),
        .req_write_data     (req_write_data),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_zero           (rsp_zero),
        .rsp_error          (rsp_error),
        .mem_address        (mem_address),
        .mem_write_data     (mem_write_data),
        .mem_read_enable    (mem_read_enable),
        .mem_read_type      (mem_read_type),
        .mem_write_enable   (mem_write_enable),
        .mem_read_data      (mem_read_data),
        .mem_operation_done (mem_operation_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Controller model
    logic [11:0] mem [0:4095];
    int          ctl_cnt = 0;
    int          done_cnt = 0;
    logic        mute = 1'b0;
    logic        force_done = 1'b0;
    logic [11:0] rd_q = 12'd0;
    logic [11:0] last_wa = 12'd0;
    logic [11:0] last_wd = 12'd0;

    always @(posedge clk) begin
        if (mem_read_enable || mem_write_enable) begin
            ctl_cnt <= 3;
        end else if (ctl_cnt != 0) begin
            ctl_cnt <= ctl_cnt - 1;
        end
        if (mem_write_enable) begin
            mem[mem_address] <= mem_write_data;
            last_wa          <= mem_address;
            last_wd          <= mem_write_data;
        end
        if (ctl_cnt == 1 && !mem_read_enable && !mem_write_enable && !mute) begin
            done_cnt <= 2;
            rd_q     <= mem[mem_address];
        end else if (done_cnt != 0) begin
            done_cnt <= done_cnt - 1;
        end
    end

    assign mem_operation_done = (done_cnt != 0) || force_done;
    assign mem_read_data      = rd_q;

    // Scoreboard and monitors
    typedef struct packed {
        logic [11:0] d;
        logic        z;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   n_rsp = 0;
    int   rd_run = 0;
    int   wr_run = 0;
    int   overlap = 0;
    int   last_en_cyc = 0;
    int   last_rsp_cyc = 0;
    logic exp_type = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready && !reset) n_acc <= n_acc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (mem_read_enable && mem_write_enable) overlap <= overlap + 1;
        if (mem_read_enable) begin
            rd_run      <= rd_run + 1;
            last_en_cyc <= cyc;
            check("read_type", 32'(mem_read_type), 32'(exp_type));
        end else begin
            if (rd_run != 0) check("rd_en_width", rd_run, 1);
            rd_run <= 0;
        end
        if (mem_write_enable) begin
            wr_run      <= wr_run + 1;
            last_en_cyc <= cyc;
        end else begin
            if (wr_run != 0) check("wr_en_width", wr_run, 1);
            wr_run <= 0;
        end
        if (rsp_valid) begin
            n_rsp        <= n_rsp + 1;
            last_rsp_cyc <= cyc;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.d));
                check("rsp_zero", 32'(rsp_zero), 32'(e.z));
                check("rsp_error", 32'(rsp_error), 32'(e.e));
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [11:0] a,
                          input logic [11:0] wd, input logic [11:0] ed,
                          input logic ez, input logic ee);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_wait", 0, 1);
        req_valid      = 1'b1;
        req_op         = op;
        req_address    = a;
        req_write_data = wd;
        exp_type       = (op == 2'b00);
        sb.push_back('{d: ed, z: ez, e: ee});
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("rsp_wait", 0, 1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int r0;
        int a0;
        logic [11:0] a;
        repeat (3) @(negedge clk);
        check("reset_ready_low", 32'(req_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 1);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rd_en", 32'(mem_read_enable), 0);
        check("reset_wr_en", 32'(mem_write_enable), 0);
        check("reset_addr", 32'(mem_address), 0);
        check("reset_wdata", 32'(mem_write_data), 0);
        check("reset_type", 32'(mem_read_type), 0);
        check("reset_rsp", {rsp_data, rsp_zero, rsp_error}, 0);

        do_req(2'b10, 12'o0200, 12'o0333, 12'o0333, 1'b0, 1'b0);
        do_req(2'b01, 12'o0200, 12'o0000, 12'o0333, 1'b0, 1'b0);

        do_req(2'b10, 12'o0000, 12'o5177, 12'o5177, 1'b0, 1'b0);
        r0 = n_rsp;
        do_req(2'b00, 12'o0000, 12'o0000, 12'o5177, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("fetch_one_rsp", n_rsp - r0, 1);

        do_req(2'b10, 12'o0300, 12'o7777, 12'o7777, 1'b0, 1'b0);
        do_req(2'b11, 12'o0300, 12'o0000, 12'o0000, 1'b1, 1'b0);
        check("rmw_wr_addr", 32'(last_wa), 32'(12'o0300));
        check("rmw_wr_data", 32'(last_wd), 32'(12'o0000));
        do_req(2'b10, 12'o0300, 12'o0004, 12'o0004, 1'b0, 1'b0);
        do_req(2'b11, 12'o0300, 12'o0000, 12'o0005, 1'b0, 1'b0);
        check("rmw_wr_data2", 32'(last_wd), 32'(12'o0005));
        do_req(2'b01, 12'o0300, 12'o0000, 12'o0005, 1'b0, 1'b0);

        mute = 1'b1;
        do_req(2'b01, 12'o0100, 12'o0000, 12'o0000, 1'b0, 1'b1);
        check("timeout_latency", last_rsp_cyc - last_en_cyc, 18);
        check("timeout_idle", 32'(req_ready), 1);
        r0 = n_acc;
        do_req(2'b11, 12'o0101, 12'o0000, 12'o0000, 1'b0, 1'b1);
        check("rmw_timeout_no_write", 32'(last_wa), 32'(12'o0300));
        mute = 1'b0;

        mute           = 1'b1;
        exp_type       = 1'b0;
        req_valid      = 1'b1;
        req_op         = 2'b01;
        req_address    = 12'o0200;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 0);
        check("rst_mid_en", {mem_read_enable, mem_write_enable}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(req_ready), 1);
        force_done = 1'b1;
        r0 = n_rsp;
        repeat (4) @(negedge clk);
        check("rst_no_rsp", n_rsp - r0, 0);
        check("rst_en_idle", {mem_read_enable, mem_write_enable}, 0);
        force_done = 1'b0;
        mute       = 1'b0;
        repeat (6) @(negedge clk);

        a0             = n_acc;
        req_valid      = 1'b1;
        req_op         = 2'b10;
        req_address    = 12'o0400;
        req_write_data = 12'o1234;
        sb.push_back('{d: 12'o1234, z: 1'b0, e: 1'b0});
        @(negedge clk);
        req_op      = 2'b01;
        req_address = 12'o0500;
        repeat (3) begin
            @(negedge clk);
            check("busy_ready", 32'(req_ready), 0);
        end
        check("busy_one_accept", n_acc - a0, 1);
        req_valid = 1'b0;
        r0 = 0;
        while (sb.size() != 0 && r0 < 200) begin
            @(negedge clk);
            r0++;
        end
        check("busy_rsp_done", sb.size(), 0);
        sb.delete();
        @(negedge clk);

        for (int i = 0; i < 4096; i++) begin
            a = 12'(i);
            do_req(2'b10, a, a ^ 12'o5252, a ^ 12'o5252, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4096; i++) begin
            a = 12'(i);
            do_req(2'b01, a, 12'o0000, a ^ 12'o5252, 1'b0, 1'b0);
        end

        check("enable_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
